// File: rtl/spi_core.sv
// Byte-oriented SPI master for I/O slot 1.
// Supports CPOL/CPHA modes 0..3 and a programmable SCLK half-period of DVSR+1 clk cycles.
//
// Ports:
//   clk, reset             system clock, asynchronous active-low reset
//   cs, read, write        slot select and read/write strobes from the I/O controller
//   addr, wr_data          register address and write data
//   rd_data                read data lane (addr 0: {23'b0, ready, rx_data})
//   miso                   serial input from the slave
//   sclk, mosi, ss_n       registered serial clock, serial output, software slave select
module spi_core #(
  parameter logic [15:0] DVSR_RST = 16'd199
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        ss_n
);

  typedef enum logic [1:0] {StIdle, StDelay, StP0, StP1} state_e;

  state_e      state_q, state_d;
  logic [15:0] dvsr_q, dvsr_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  // Working copies, frozen for the duration of a transfer.
  logic [15:0] w_dvsr_q, w_dvsr_d;
  logic        w_cpol_q, w_cpol_d;
  logic        w_cpha_q, w_cpha_d;
  logic        ss_n_q, ss_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  tx_sreg_q, tx_sreg_d;
  logic [7:0]  rx_sreg_q, rx_sreg_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cnt_q, cnt_d;

  logic wr_en, start, last, pclk, ready;
  logic unused_wr_data;

  assign unused_wr_data = ^wr_data[31:18];

  assign wr_en = cs & write;
  assign ready = (state_q == StIdle);
  assign start = wr_en && (addr == 5'd3) && ready;
  assign last  = (cnt_q == w_dvsr_q);
  assign pclk  = w_cpha_q ? (state_q == StP0) : (state_q == StP1);

  always_comb begin
    state_d   = state_q;
    dvsr_d    = dvsr_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    w_dvsr_d  = w_dvsr_q;
    w_cpol_d  = w_cpol_q;
    w_cpha_d  = w_cpha_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;
    tx_sreg_d = tx_sreg_q;
    rx_sreg_d = rx_sreg_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    sclk_d    = pclk ^ w_cpol_q;

    if (wr_en && addr == 5'd1) begin
      ss_n_d = wr_data[0];
    end
    if (wr_en && addr == 5'd2) begin
      dvsr_d = wr_data[15:0];
      cpol_d = wr_data[16];
      cpha_d = wr_data[17];
    end

    if (state_q != StIdle) begin
      cnt_d = last ? 16'd0 : cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        // Track the programmed settings while idle so sclk rests at the current cpol.
        w_dvsr_d = dvsr_q;
        w_cpol_d = cpol_q;
        w_cpha_d = cpha_q;
        if (start) begin
          tx_sreg_d = wr_data[7:0];
          mosi_d    = wr_data[7];
          bit_cnt_d = 3'd0;
          cnt_d     = 16'd0;
          state_d   = cpha_q ? StDelay : StP0;
        end
      end
      StDelay: begin
        if (last) state_d = StP0;
      end
      StP0: begin
        if (last) begin
          rx_sreg_d = {rx_sreg_q[6:0], miso};
          state_d   = StP1;
        end
      end
      StP1: begin
        if (last) begin
          if (bit_cnt_q == 3'd7) begin
            rx_data_d = rx_sreg_q;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_sreg_d = {tx_sreg_q[6:0], 1'b0};
            mosi_d    = tx_sreg_q[6];
            state_d   = StP0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      dvsr_q    <= DVSR_RST;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      w_dvsr_q  <= DVSR_RST;
      w_cpol_q  <= 1'b0;
      w_cpha_q  <= 1'b0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_sreg_q <= 8'd0;
      rx_sreg_q <= 8'd0;
      rx_data_q <= 8'd0;
      bit_cnt_q <= 3'd0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      dvsr_q    <= dvsr_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      w_dvsr_q  <= w_dvsr_d;
      w_cpol_q  <= w_cpol_d;
      w_cpha_q  <= w_cpha_d;
      ss_n_q    <= ss_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tx_sreg_q <= tx_sreg_d;
      rx_sreg_q <= rx_sreg_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (cs && read && addr == 5'd0) begin
      rd_data = {23'd0, ready, rx_data_q};
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign ss_n = ss_n_q;

endmodule
